off_chip_rx_deser: RTL and testbench

Receive end of the off-chip 16-bit link. Collects four byte-interleaved 16-bit beats into one 64-bit word and buffers completed words in a small first-word-fall-through (FWFT) FIFO. Presents words downstream on a valid/ready interface. Returns one credit per consumed word to the link transmitter; the transmitter's credit counter is initialised to DEPTH.

---
 rtl/off_chip_rx_deser_pkg.sv | 33 +++
 rtl/off_chip_rx_deser_fifo.sv | 73 +++++++
 rtl/off_chip_rx_deser.sv | 99 +++++++++
 tb/tb_off_chip_rx_deser.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/off_chip_rx_deser_pkg.sv
// Shared definitions for the off-chip 16-bit link: widths, beat index type and
// the byte-interleave mapping used by both the transmit and receive ends.
package off_chip_pkg;

    localparam int LINK_W         = 16;
    localparam int WORD_W         = 64;
    localparam int BEATS_PER_WORD = 4;
    localparam int BEAT_IDX_W     = $clog2(BEATS_PER_WORD);

    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;
    typedef logic [LINK_W-1:0]     link_beat_t;
    typedef logic [WORD_W-1:0]     link_word_t;

    localparam beat_idx_t FIRST_BEAT = '0;
    localparam beat_idx_t LAST_BEAT  = beat_idx_t'(BEATS_PER_WORD - 1);

    // Beat k carries byte k of each 32-bit half: low byte -> word[8k+:8], high byte -> word[8k+32+:8].
    function automatic link_word_t insert_beat(input link_word_t word,
                                               input beat_idx_t  k,
                                               input link_beat_t beat);
        link_word_t w;
        w = word;
        w[8*int'(k) +: 8]      = beat[7:0];
        w[8*int'(k) + 32 +: 8] = beat[15:8];
        return w;
    endfunction

    function automatic link_beat_t extract_beat(input link_word_t word,
                                                input beat_idx_t  k);
        return {word[8*int'(k) + 32 +: 8], word[8*int'(k) +: 8]};
    endfunction

endpackage

// File: rtl/off_chip_rx_deser_fifo.sv
// First-word-fall-through FIFO: head entry is presented combinationally from
// the storage registers; pointers carry a wrap bit to tell full from empty.
module off_chip_rx_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [PTR_W:0]   wptr_q, wptr_d;
    logic [PTR_W:0]   rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;
    logic [PTR_W-1:0] waddr;
    logic [PTR_W-1:0] raddr;

    assign waddr = wptr_q[PTR_W-1:0];
    assign raddr = rptr_q[PTR_W-1:0];

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) && (waddr == raddr);
    assign count = wptr_q - rptr_q;
    assign rdata = mem_q[raddr];

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign mem_d[gi] = (push_ok && (waddr == PTR_W'(gi))) ? wdata : mem_q[gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                mem_q[gi] <= '0;
            end else begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    end

endmodule

// File: rtl/off_chip_rx_deser.sv
// Receive end of the off-chip link: assembles four interleaved beats into a
// 64-bit word, buffers it, returns one credit per consumed word.
module off_chip_rx_deser
    import off_chip_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              link_valid,
    input  logic              link_sof,
    input  logic [LINK_W-1:0] link_data,
    input  logic              ready,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              credit_ret,
    output logic              err_overflow,
    output logic              err_framing,
    output logic [PTR_W:0]    fill_level
);

    beat_idx_t  cnt_q, cnt_d;
    link_word_t asm_q, asm_d;
    logic       credit_q, credit_d;
    logic       overflow_q, overflow_d;
    logic       framing_q, framing_d;

    beat_idx_t  beat_idx;
    link_word_t beat_word;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;

    // A start-of-frame beat always restarts assembly at beat 0.
    assign beat_idx  = link_sof ? FIRST_BEAT : cnt_q;
    assign beat_word = insert_beat((beat_idx == FIRST_BEAT) ? '0 : asm_q, beat_idx, link_data);

    always_comb begin
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        push      = 1'b0;
        framing_d = framing_q;
        if (link_valid) begin
            if (link_sof && (cnt_q != FIRST_BEAT)) begin
                framing_d = 1'b1;
            end
            if (beat_idx == LAST_BEAT) begin
                push  = 1'b1;
                cnt_d = FIRST_BEAT;
            end else begin
                asm_d = beat_word;
                cnt_d = beat_idx + 1'b1;
            end
        end
    end

    assign pop        = ready && !fifo_empty;
    assign credit_d   = pop;
    assign overflow_d = overflow_q || (push && fifo_full && !pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= FIRST_BEAT;
            asm_q      <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
            framing_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
            framing_q  <= framing_d;
        end
    end

    off_chip_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (beat_word),
        .pop   (pop),
        .rdata (data_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill_level)
    );

    assign valid_out    = !fifo_empty;
    assign credit_ret   = credit_q;
    assign err_overflow = overflow_q;
    assign err_framing  = framing_q;

endmodule

// File: tb/tb_off_chip_rx_deser.sv
// Bench for off_chip_rx_deser: queue-based word model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_off_chip_rx_deser;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        link_valid = 1'b0;
    logic        link_sof = 1'b0;
    logic [15:0] link_data = 16'h0;
    logic        ready = 1'b0;
    logic [63:0] data_out;
    logic        valid_out;
    logic        credit_ret;
    logic        err_overflow;
    logic        err_framing;
    logic [3:0]  fill_level;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [63:0] mq[$];
    logic [63:0] dq[$];
    logic [15:0] mbeats[4];
    int          mcnt = 0;
    bit          m_ovf = 0;
    bit          m_frm = 0;
    bit          m_credit = 0;
    bit          started = 0;
    int          model_pops = 0;
    int          seen_credits = 0;
    bit          do_pop;
    bit          do_push;
    logic [63:0] mword;

    off_chip_rx_deser #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .link_valid   (link_valid),
        .link_sof     (link_sof),
        .link_data    (link_data),
        .ready        (ready),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .credit_ret   (credit_ret),
        .err_overflow (err_overflow),
        .err_framing  (err_framing),
        .fill_level   (fill_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: words are built from the collected beats by plain shifting.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mcnt     = 0;
            m_ovf    = 0;
            m_frm    = 0;
            m_credit = 0;
            started  = 1;
        end else if (started) begin
            do_pop  = ready && (mq.size() > 0);
            do_push = 0;
            mword   = 64'h0;
            if (link_valid) begin
                if (link_sof) begin
                    if (mcnt != 0) m_frm = 1;
                    mcnt = 0;
                end
                mbeats[mcnt] = link_data;
                mcnt++;
                if (mcnt == 4) begin
                    for (int k = 0; k < 4; k++) begin
                        mword |= 64'(mbeats[k][7:0]) << (8 * k);
                        mword |= 64'(mbeats[k][15:8]) << (8 * k + 32);
                    end
                    mcnt    = 0;
                    do_push = 1;
                end
            end
            m_credit = do_pop;
            if (do_pop) begin
                dq.push_back(mq[0]);
                $display("pop  word=%h fill_before=%0d", mq[0], mq.size());
                void'(mq.pop_front());
                model_pops++;
            end
            if (do_push) begin
                if (mq.size() >= DEPTH) begin
                    m_ovf = 1;
                    $display("drop word=%h (fifo full)", mword);
                end else begin
                    mq.push_back(mword);
                    $display("push word=%h", mword);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("valid_out", 64'(valid_out), 64'(mq.size() != 0));
            check("fill_level", 64'(fill_level), 64'(mq.size()));
            if (mq.size() != 0) check("data_out", data_out, mq[0]);
            check("credit_ret", 64'(credit_ret), 64'(m_credit));
            check("err_overflow", 64'(err_overflow), 64'(m_ovf));
            check("err_framing", 64'(err_framing), 64'(m_frm));
            if (credit_ret === 1'b1) seen_credits++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit v, input bit s, input logic [15:0] d, input bit r);
        #1;
        rst        = 1'b0;
        link_valid = v;
        link_sof   = s;
        link_data  = d;
        ready      = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit r);
        drive(1'b0, 1'b0, 16'h0, r);
    endtask

    task automatic reset_dut(input bit beat_in_reset);
        #1;
        rst        = 1'b1;
        link_valid = beat_in_reset;
        link_sof   = 1'b0;
        link_data  = 16'h9999;
        ready      = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [63:0] w, input bit r_last);
        logic [15:0] b;
        for (int k = 0; k < 4; k++) begin
            b = {w[8*k+32 +: 8], w[8*k +: 8]};
            drive(1'b1, k == 0, b, (k == 3) ? r_last : 1'b0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && valid_out === 1'b1; i++) idle(1'b1);
        check("drain_empty", 64'(valid_out), 64'h0);
        idle(1'b0);
    endtask

    function automatic logic [63:0] wgen(input int i);
        return {32'(i) * 32'h0101_0101, ~(32'(i) * 32'h0010_0011)};
    endfunction

    int credits_before;

    initial begin
        @(negedge clk);
        reset_dut(1'b0);
        check("rst_data_out", data_out, 64'h0);
        check("rst_valid_out", 64'(valid_out), 64'h0);
        check("rst_fill_level", 64'(fill_level), 64'h0);
        check("rst_flags", {62'h0, err_overflow, err_framing}, 64'h0);

        // Single word with literal beats
        drive(1'b1, 1'b1, 16'h4488, 1'b0);
        drive(1'b1, 1'b0, 16'h3377, 1'b0);
        drive(1'b1, 1'b0, 16'h2266, 1'b0);
        drive(1'b1, 1'b0, 16'h1155, 1'b0);
        check("single_valid", 64'(valid_out), 64'h1);
        check("single_data", data_out, 64'h1122_3344_5566_7788);
        check("model_single_word", mq[0], 64'h1122_3344_5566_7788);
        idle(1'b1);
        check("single_credit_pulse", 64'(credit_ret), 64'h1);
        idle(1'b0);
        check("single_credit_end", 64'(credit_ret), 64'h0);
        check("single_empty", 64'(valid_out), 64'h0);

        // Fill with ready low, ninth word overflows
        reset_dut(1'b0);
        dq.delete();
        credits_before = seen_credits;
        for (int i = 1; i <= 9; i++) send_word(wgen(i), 1'b0);
        check("fill_level_full", 64'(fill_level), 64'h8);
        check("fill_overflow", 64'(err_overflow), 64'h1);
        drain();
        check("fill_delivered", 64'(dq.size()), 64'h8);
        check("fill_first", dq[0], wgen(1));
        check("fill_last", dq[dq.size()-1], wgen(8));
        check("fill_credits", 64'(seen_credits - credits_before), 64'h8);

        // Full FIFO with push and pop on the same edge
        reset_dut(1'b0);
        dq.delete();
        for (int i = 1; i <= 8; i++) send_word(wgen(i), 1'b0);
        send_word(wgen(9), 1'b1);
        check("simul_fill", 64'(fill_level), 64'h8);
        check("simul_no_overflow", 64'(err_overflow), 64'h0);
        drain();
        check("simul_delivered", 64'(dq.size()), 64'h9);
        check("simul_last", dq[dq.size()-1], wgen(9));

        // Framing error: partial word discarded on a mid-word sof
        reset_dut(1'b0);
        dq.delete();
        drive(1'b1, 1'b1, 16'hAAAA, 1'b0);
        drive(1'b1, 1'b0, 16'hBBBB, 1'b0);
        drive(1'b1, 1'b1, 16'h4488, 1'b0);
        drive(1'b1, 1'b0, 16'h3377, 1'b0);
        drive(1'b1, 1'b0, 16'h2266, 1'b0);
        drive(1'b1, 1'b0, 16'h1155, 1'b0);
        check("framing_flag", 64'(err_framing), 64'h1);
        check("framing_fill", 64'(fill_level), 64'h1);
        check("framing_data", data_out, 64'h1122_3344_5566_7788);
        drain();
        check("framing_delivered", 64'(dq.size()), 64'h1);

        // Reset in the middle of a word, with a beat present during reset
        reset_dut(1'b0);
        drive(1'b1, 1'b1, 16'hDEAD, 1'b0);
        drive(1'b1, 1'b0, 16'hBEEF, 1'b0);
        reset_dut(1'b1);
        send_word(64'h0123_4567_89AB_CDEF, 1'b0);
        check("midrst_fill", 64'(fill_level), 64'h1);
        check("midrst_flags", {62'h0, err_overflow, err_framing}, 64'h0);
        check("midrst_data", data_out, 64'h0123_4567_89AB_CDEF);
        drain();

        // Randomized traffic: gaps, occasional stray sof, toggling ready
        reset_dut(1'b0);
        for (int c = 0; c < 3000; c++) begin
            bit v;
            bit s;
            v = ($urandom % 100) < 55;
            s = (mcnt == 0) ? bit'($urandom % 2) : (($urandom % 100) < 3);
            drive(v, s, 16'($urandom), bit'($urandom % 2));
        end
        drain();
        idle(1'b0);
        check("credit_total", 64'(seen_credits), 64'(model_pops));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
